// File: rtl/pk_stream_pkg.sv
// Shared constants and helpers for the public-key stream reader.
// Derives memory depth, address width and beats per word; defines the FSM encoding.
package pk_stream_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int depth_f(input int l, input int k, input int n);
        return (l * k) / n;
    endfunction

    // Bit width needed to index 'count' items, never below one bit.
    function automatic int clogb_f(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int beats_f(input int n, input int m, input int out_w);
        return (n * m) / out_w;
    endfunction

endpackage

// File: rtl/pk_word_serializer.sv
// Two-entry word buffer feeding a registered OUT_W-bit valid/ready stage.
// Words are split LSB-first into W/OUT_W beats; a word leaves the buffer when its last beat is loaded.
module pk_word_serializer
    import pk_stream_pkg::*;
#(
    parameter int W     = 40,
    parameter int OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             push_last_i,
    input  logic [W-1:0]     word_i,
    input  logic             out_ready_i,
    output logic [1:0]       occ_o,
    output logic             out_valid_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_last_o
);

    localparam int R  = W / OUT_W;
    localparam int BW = clogb_f(R);
    localparam logic [BW-1:0] BEAT_LAST = BW'(R - 1);

    logic [W-1:0]          word_buf_q [2];
    logic                  last_buf_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;
    logic [BW-1:0]         beat_q;
    logic                  out_valid_q;
    logic [OUT_W-1:0]      out_data_q;
    logic                  out_last_q;

    logic [W-1:0]          head_word_s;
    logic                  head_last_s;
    logic [R-1:0][OUT_W-1:0] beats_s;
    logic                  avail_s;
    logic                  load_s;
    logic                  beat_is_last_s;
    logic                  pop_s;

    // An empty buffer forwards the word arriving this cycle so the first beat costs no extra cycle.
    always_comb begin
        head_word_s = word_i;
        head_last_s = push_last_i;
        if (cnt_q != 2'd0) begin
            head_word_s = word_buf_q[rd_ptr_q];
            head_last_s = last_buf_q[rd_ptr_q];
        end else begin
            head_word_s = word_i;
            head_last_s = push_last_i;
        end
    end

    assign beats_s        = head_word_s;
    assign avail_s        = (cnt_q != 2'd0) || push_i;
    assign load_s         = avail_s && (!out_valid_q || out_ready_i);
    assign beat_is_last_s = (beat_q == BEAT_LAST);
    assign pop_s          = load_s && beat_is_last_s;
    assign cnt_d          = 2'(cnt_q + 2'(push_i) - 2'(pop_s));

    // Buffer storage, pointers, beat index and the registered stream stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_buf_q  <= '{default: '0};
            last_buf_q  <= '{default: 1'b0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (push_i) begin
                word_buf_q[wr_ptr_q] <= word_i;
                last_buf_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
            if (load_s) begin
                beat_q      <= beat_is_last_s ? '0 : BW'(beat_q + 1'b1);
                out_valid_q <= 1'b1;
                out_data_q  <= beats_s[beat_q];
                out_last_q  <= head_last_s && beat_is_last_s;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign occ_o       = cnt_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

endmodule

// File: rtl/pk_stream_reader.sv
// Sweeps the systemizer public-key memory and streams it out as OUT_W-bit beats.
// Optional PK_STREAM_READER_CHECKSUM_EN adds a running XOR of all transferred beats.
module pk_stream_reader
    import pk_stream_pkg::*;
#(
    parameter  int N     = 20,
    parameter  int M     = 2,
    parameter  int L     = 200,
    parameter  int K     = 400,
    parameter  int OUT_W = 8,
    localparam int DEPTH = depth_f(L, K, N),
    localparam int AW    = clogb_f(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [AW-1:0]    rd_addr_o,
    input  logic [N*M-1:0]   rd_data_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o
`ifdef PK_STREAM_READER_CHECKSUM_EN
    ,
    output logic [OUT_W-1:0] checksum_o
`endif
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   rd_addr_q;
    logic [AW-1:0]   rd_addr_d;
    logic            inflight_q;
    logic            inflight_last_q;

    logic [1:0]       occ_s;
    logic             start_ok_s;
    logic             rd_en_s;
    logic             last_issue_s;
    logic             xfer_s;
    logic             xfer_last_s;
    logic             out_valid_s;
    logic             out_last_s;
    logic [OUT_W-1:0] out_data_s;

    assign start_ok_s   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Buffered words plus the read in flight may never exceed the two buffer slots.
    assign rd_en_s      = (state_q == ST_FETCH) && (({1'b0, occ_s} + {2'b00, inflight_q}) < 3'd2);
    assign last_issue_s = rd_en_s && (rd_addr_q == ADDR_LAST);
    assign xfer_s       = out_valid_s && out_ready_i;
    assign xfer_last_s  = xfer_s && out_last_s;

    // Sweep sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) state_d = ST_FETCH;
                else            state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (last_issue_s) state_d = ST_DRAIN;
                else              state_d = ST_FETCH;
            end
            ST_DRAIN: begin
                if (xfer_last_s && (occ_s == 2'd0) && !inflight_q) state_d = ST_DONE;
                else                                               state_d = ST_DRAIN;
            end
            ST_DONE: begin
                if (start_ok_s) state_d = ST_FETCH;
                else            state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address advances per issued read and parks on the final address.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (start_ok_s) begin
            rd_addr_d = '0;
        end else if (rd_en_s && !last_issue_s) begin
            rd_addr_d = AW'(rd_addr_q + 1'b1);
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // FSM, address counter and one-deep read-latency tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            inflight_q      <= rd_en_s;
            inflight_last_q <= last_issue_s;
        end
    end

    pk_word_serializer #(
        .W     (N * M),
        .OUT_W (OUT_W)
    ) u_ser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_last_i (inflight_last_q),
        .word_i      (rd_data_i),
        .out_ready_i (out_ready_i),
        .occ_o       (occ_s),
        .out_valid_o (out_valid_s),
        .out_data_o  (out_data_s),
        .out_last_o  (out_last_s)
    );

`ifdef PK_STREAM_READER_CHECKSUM_EN
    logic [OUT_W-1:0] checksum_q;
    logic [OUT_W-1:0] checksum_d;

    // Running XOR; cleared by an accepted start, untouched between sweeps.
    always_comb begin
        checksum_d = checksum_q;
        if (start_ok_s) begin
            checksum_d = '0;
        end else if (xfer_s) begin
            checksum_d = checksum_q ^ out_data_s;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`endif

    assign busy_o      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_DONE);
    assign rd_en_o     = rd_en_s;
    assign rd_addr_o   = rd_addr_q;
    assign out_valid_o = out_valid_s;
    assign out_data_o  = out_data_s;
    assign out_last_o  = out_last_s;

endmodule

// File: tb/tb_pk_stream_reader.sv
// Directed sweeps of pk_stream_reader with randomized sink backpressure, checked against
// a beat list built directly from the memory contents word[a] = a*3+1.
module tb_pk_stream_reader;

    localparam int N     = 4;
    localparam int M     = 2;
    localparam int L     = 8;
    localparam int K     = 16;
    localparam int OUT_W = 4;
    localparam int DEPTH = 32;
    localparam int TOTAL = 64;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic       rd_en_o;
    logic [4:0] rd_addr_o;
    logic [7:0] rd_data_i;
    logic [3:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       out_last_o;
`ifdef PK_STREAM_READER_CHECKSUM_EN
    logic [3:0] checksum_o;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_xor;

    pk_stream_reader #(
        .N(N), .M(M), .L(L), .K(K), .OUT_W(OUT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o)
`ifdef PK_STREAM_READER_CHECKSUM_EN
        ,
        .checksum_o  (checksum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Systemizer memory: data appears one cycle after the read strobe.
    always @(posedge clk_i) begin
        if (rd_en_o) rd_data_i <= 8'(int'(rd_addr_o) * 3 + 1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low 20 cycles, 3: restart attempt at beat 30.
    // abort_at >= 0 asserts rst when that many beats have transferred.
    task automatic sweep(input int mode, input int abort_at);
        int   scyc;
        int   idx;
        int   rd_stall;
        int   first_valid;
        bit   finished;
        bit   pulsed;
        logic xfer;
        start_i = 1'b1;
        scyc    = cyc;
        tick();
        start_i = 1'b0;
        chk("rd_en_after_start", rd_en_o, 1'b1);
        chk("rd_addr_first", rd_addr_o, 5'd0);
        idx = 0; rd_stall = 0; first_valid = -1; finished = 0; pulsed = 0;
        for (int n = 0; n < 2000; n++) begin
            if (rd_en_o && (cyc <= scyc + 20)) rd_stall++;
            if (done_o) begin
                finished = 1;
                chk("beats_at_done", idx, TOTAL);
                chk("busy_low_at_done", busy_o, 1'b0);
                if (mode == 0) chk("done_cycle", cyc, scyc + 3 + TOTAL);
`ifdef PK_STREAM_READER_CHECKSUM_EN
                chk("checksum", checksum_o, exp_xor);
`endif
                break;
            end
            chk("busy", busy_o, 1'b1);
            if (out_valid_o) begin
                if (first_valid < 0) first_valid = cyc;
                if (idx >= TOTAL) chk("beat_overrun", idx, TOTAL - 1);
                else begin
                    chk("out_data", out_data_o, exp_q[idx]);
                    chk("out_last", out_last_o, (idx == TOTAL - 1));
                end
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst_i = 1'b1;
                #1;
                chk("rst_busy", busy_o, 1'b0);
                chk("rst_rd_en", rd_en_o, 1'b0);
                chk("rst_rd_addr", rd_addr_o, 5'd0);
                chk("rst_valid", out_valid_o, 1'b0);
                chk("rst_last", out_last_o, 1'b0);
                chk("rst_data", out_data_o, 4'h0);
                chk("rst_done", done_o, 1'b0);
                finished = 1;
                break;
            end
            case (mode)
                1:       out_ready_i = 1'($urandom_range(0, 1));
                2:       out_ready_i = (cyc > scyc + 20);
                default: out_ready_i = 1'b1;
            endcase
            start_i = (mode == 3) && (idx == 30) && !pulsed;
            if (start_i) pulsed = 1;
            xfer = out_valid_o && out_ready_i;
            tick();
            if (xfer) idx++;
        end
        start_i = 1'b0;
        chk("sweep_finished", finished, 1'b1);
        chk("first_valid_cycle", first_valid, scyc + 3);
        if (mode == 2) chk("stall_reads_le_2", (rd_stall <= 2), 1'b1);
        if (abort_at >= 0) begin
            tick();
            tick();
            rst_i = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] w;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        out_ready_i = 1'b0;
        exp_xor     = 4'h0;
        for (int a = 0; a < DEPTH; a++) begin
            w = 8'(a * 3 + 1);
            exp_q.push_back(w[3:0]);
            exp_q.push_back(w[7:4]);
            exp_xor = exp_xor ^ w[3:0] ^ w[7:4];
        end
        repeat (3) tick();
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_valid", out_valid_o, 1'b0);
        chk("reset_addr", rd_addr_o, 5'd0);
        rst_i = 1'b0;
        while (cyc < 10) tick();

        sweep(0, -1);
        // Next start lands in the done cycle of the previous sweep.
        sweep(1, -1);
        repeat (5) tick();
        sweep(2, -1);
        repeat (3) tick();
        sweep(3, -1);
        tick();
        repeat (3) begin
            chk("single_done", done_o, 1'b0);
            tick();
        end
        repeat (2) tick();
        sweep(0, 17);
        repeat (3) tick();
        sweep(0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
